ppi_bus_master: RTL and testbench

Synchronous CPU-side sequencer that sits directly upstream of the `ppi` block and drives its asynchronous microprocessor bus: `rdb`, `wrb`, `address` and `data`. The block takes single-beat read/write commands over a valid/ready interface. It turns each command into a correctly timed strobe cycle with programmable setup, strobe and hold phases. It returns read data as a one-cycle response. It also synchronises the PPI's INTRA and INTRB handshake outputs (PortC[3] and PortC[0]) into the clock domain as edge pulses.

---
 rtl/ppi_bus_master.sv | 133 +++++++++++++
 tb/tb_ppi_bus_master.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ppi_bus_master.sv
// CPU-side sequencer for the PPI microprocessor bus: turns valid/ready commands into
// setup/strobe/hold timed rdb/wrb cycles and synchronises INTRA/INTRB into edge pulses.
module ppi_bus_master #(
    parameter int unsigned SETUP_CYC  = 2,
    parameter int unsigned STROBE_CYC = 4,
    parameter int unsigned HOLD_CYC   = 2
) (
    input  logic       clk,
    input  logic       resetb,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic [2:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rdb,
    output logic       wrb,
    output logic [2:0] address,
    output logic [7:0] data_out,
    output logic       data_oe,
    input  logic [7:0] data_in,
    input  logic       intra_in,
    input  logic       intrb_in,
    output logic       irq_a,
    output logic       irq_b
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD
    } state_t;

    localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC);
    localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC);
    localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC);

    state_t     state;
    logic [3:0] phase_cnt;
    logic       wr_q;
    logic       accept;
    logic [2:0] sync_a;
    logic [2:0] sync_b;

    // Gating with resetb keeps ready low for as long as reset is held.
    assign cmd_ready = resetb && (state == IDLE);
    assign accept    = cmd_valid && cmd_ready;

    // NOTE: every register here, including the captured command, is cleared by the
    // synchronous reset, and all sequential state uses non-blocking assignments so
    // each branch sees the pre-edge values of phase_cnt and wr_q.
    always_ff @(posedge clk) begin
        if (!resetb) begin
            state     <= IDLE;
            phase_cnt <= '0;
            wr_q      <= 1'b0;
            rdb       <= 1'b1;
            wrb       <= 1'b1;
            address   <= '0;
            data_out  <= '0;
            data_oe   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state     <= SETUP;
                        phase_cnt <= SETUP_LD;
                        wr_q      <= cmd_write;
                        address   <= cmd_addr;
                        data_out  <= cmd_wdata;
                        data_oe   <= cmd_write;
                    end
                end
                SETUP: begin
                    if (phase_cnt == 4'd1) begin
                        state     <= STROBE;
                        phase_cnt <= STROBE_LD;
                        rdb       <= wr_q;
                        wrb       <= !wr_q;
                    end else begin
                        phase_cnt <= phase_cnt - 4'd1;
                    end
                end
                STROBE: begin
                    if (phase_cnt == 4'd1) begin
                        state     <= HOLD;
                        phase_cnt <= HOLD_LD;
                        rdb       <= 1'b1;
                        wrb       <= 1'b1;
                        // Sampled on the edge that ends the last strobe cycle.
                        if (!wr_q) begin
                            rsp_valid <= 1'b1;
                            rsp_rdata <= data_in;
                        end
                    end else begin
                        phase_cnt <= phase_cnt - 4'd1;
                    end
                end
                HOLD: begin
                    if (phase_cnt == 4'd1) begin
                        state     <= IDLE;
                        phase_cnt <= '0;
                        data_oe   <= 1'b0;
                    end else begin
                        phase_cnt <= phase_cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // [0],[1] are the synchroniser stages, [2] is the edge-detect delay.
    always_ff @(posedge clk) begin
        if (!resetb) begin
            sync_a <= '0;
            sync_b <= '0;
            irq_a  <= 1'b0;
            irq_b  <= 1'b0;
        end else begin
            sync_a <= {sync_a[1:0], intra_in};
            sync_b <= {sync_b[1:0], intrb_in};
            irq_a  <= sync_a[1] && !sync_a[2];
            irq_b  <= sync_b[1] && !sync_b[2];
        end
    end

endmodule

// File: tb/tb_ppi_bus_master.sv
// Scoreboard bench for ppi_bus_master: stimulus pushes per-cycle expectations,
// responses and IRQ pulses into queues; a negedge monitor pops and compares.
module tb_ppi_bus_master;

    typedef struct {
        int         dut;
        int         cyc;
        logic       rdb;
        logic       wrb;
        logic       oe;
        logic       rsp;
        logic       rdy;
        logic       chk_bus;
        logic [2:0] addr;
        logic [7:0] dout;
        logic       chk_rd;
        logic [7:0] rd;
    } snap_t;

    typedef struct {
        int         cyc;
        logic [7:0] data;
    } rsp_t;

    logic       clk;
    logic       resetb;
    logic       cmd_valid;
    logic       f_cmd_valid;
    logic       cmd_write;
    logic [2:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic [7:0] data_in;
    logic       intra_in;
    logic       intrb_in;

    logic       m_cmd_ready, m_rsp_valid, m_rdb, m_wrb, m_data_oe, m_irq_a, m_irq_b;
    logic [7:0] m_rsp_rdata, m_data_out;
    logic [2:0] m_address;
    logic       f_cmd_ready, f_rsp_valid, f_rdb, f_wrb, f_data_oe, f_irq_a, f_irq_b;
    logic [7:0] f_rsp_rdata, f_data_out;
    logic [2:0] f_address;

    int    cyc = 0;
    int    n_vec = 0;
    int    n_bad = 0;
    snap_t snap_q[$];
    rsp_t  rsp_q0[$];
    rsp_t  rsp_q1[$];
    int    irq_a_q[$];

    ppi_bus_master u_dut (
        .clk(clk), .resetb(resetb), .cmd_valid(cmd_valid), .cmd_ready(m_cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(m_rsp_valid), .rsp_rdata(m_rsp_rdata), .rdb(m_rdb), .wrb(m_wrb),
        .address(m_address), .data_out(m_data_out), .data_oe(m_data_oe),
        .data_in(data_in), .intra_in(intra_in), .intrb_in(intrb_in),
        .irq_a(m_irq_a), .irq_b(m_irq_b)
    );

    ppi_bus_master #(.SETUP_CYC(1), .STROBE_CYC(1), .HOLD_CYC(1)) u_fast (
        .clk(clk), .resetb(resetb), .cmd_valid(f_cmd_valid), .cmd_ready(f_cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(f_rsp_valid), .rsp_rdata(f_rsp_rdata), .rdb(f_rdb), .wrb(f_wrb),
        .address(f_address), .data_out(f_data_out), .data_oe(f_data_oe),
        .data_in(data_in), .intra_in(1'b0), .intrb_in(1'b0),
        .irq_a(f_irq_a), .irq_b(f_irq_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle n begins at the (n-1)th rising edge and ends at the nth.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        n_vec++;
        n_bad++;
        $display("FAIL %s: observed at cycle %0d, none expected", name, cyc);
    endtask

    function automatic logic [4:0] trace_bits(input int dut);
        if (dut == 0) return {m_rdb, m_wrb, m_data_oe, m_rsp_valid, m_cmd_ready};
        return {f_rdb, f_wrb, f_data_oe, f_rsp_valid, f_cmd_ready};
    endfunction

    function automatic logic [10:0] bus_bits(input int dut);
        if (dut == 0) return {m_address, m_data_out};
        return {f_address, f_data_out};
    endfunction

    function automatic logic [7:0] rd_bits(input int dut);
        if (dut == 0) return m_rsp_rdata;
        return f_rsp_rdata;
    endfunction

    task automatic goto(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_reset(input int dut, input int n, input logic rdy);
        snap_t e;
        e = '{dut: dut, cyc: n, rdb: 1'b1, wrb: 1'b1, oe: 1'b0, rsp: 1'b0, rdy: rdy,
              chk_bus: 1'b1, addr: 3'd0, dout: 8'h00, chk_rd: 1'b1, rd: 8'h00};
        snap_q.push_back(e);
    endtask

    // Expected trace for a command accepted at edge k; abort_cyc > 0 stops the trace there.
    task automatic push_txn(input int dut, input int k, input logic write, input logic [2:0] addr,
                            input logic [7:0] wdata, input logic [7:0] rdata,
                            input int s, input int t, input int h, input int abort_cyc);
        snap_t e;
        rsp_t  r;
        int    l;
        logic  strobe;
        l = s + t + h;
        for (int p = 1; p <= l + 1; p++) begin
            if (abort_cyc > 0 && k + p > abort_cyc) break;
            strobe = (p > s) && (p <= s + t);
            e.dut = dut;
            e.cyc = k + p;
            e.chk_bus = 1'b1;
            e.addr = addr;
            e.dout = wdata;
            e.chk_rd = 1'b0;
            e.rd = 8'h00;
            if (p <= l) begin
                e.rdb = !(strobe && !write);
                e.wrb = !(strobe && write);
                e.oe  = write;
                e.rsp = !write && (p == s + t + 1);
                e.rdy = 1'b0;
            end else begin
                e.rdb = 1'b1;
                e.wrb = 1'b1;
                e.oe  = 1'b0;
                e.rsp = 1'b0;
                e.rdy = 1'b1;
            end
            snap_q.push_back(e);
        end
        if (!write && abort_cyc == 0) begin
            r.cyc  = k + s + t + 1;
            r.data = rdata;
            if (dut == 0) rsp_q0.push_back(r);
            else rsp_q1.push_back(r);
        end
    endtask

    // Monitor: trace snapshots, responses, IRQ pulses and the strobe-exclusion invariant.
    always @(negedge clk) begin
        rsp_t r;
        int   c;
        for (int i = int'(snap_q.size()) - 1; i >= 0; i--) begin
            if (snap_q[i].cyc == cyc) begin
                check($sformatf("trace dut%0d cyc%0d {rdb,wrb,oe,rsp,rdy}", snap_q[i].dut, cyc),
                      32'(trace_bits(snap_q[i].dut)),
                      32'({snap_q[i].rdb, snap_q[i].wrb, snap_q[i].oe, snap_q[i].rsp, snap_q[i].rdy}));
                if (snap_q[i].chk_bus)
                    check($sformatf("bus dut%0d cyc%0d {addr,data_out}", snap_q[i].dut, cyc),
                          32'(bus_bits(snap_q[i].dut)), 32'({snap_q[i].addr, snap_q[i].dout}));
                if (snap_q[i].chk_rd)
                    check($sformatf("rsp_rdata dut%0d cyc%0d", snap_q[i].dut, cyc),
                          32'(rd_bits(snap_q[i].dut)), 32'(snap_q[i].rd));
                snap_q.delete(i);
            end
        end
        if (m_rsp_valid === 1'b1) begin
            if (rsp_q0.size() == 0) unexpected("rsp_valid dut0");
            else begin
                r = rsp_q0.pop_front();
                check("rsp cycle dut0", 32'(cyc), 32'(r.cyc));
                check("rsp data dut0", 32'(m_rsp_rdata), 32'(r.data));
            end
        end
        if (f_rsp_valid === 1'b1) begin
            if (rsp_q1.size() == 0) unexpected("rsp_valid dut1");
            else begin
                r = rsp_q1.pop_front();
                check("rsp cycle dut1", 32'(cyc), 32'(r.cyc));
                check("rsp data dut1", 32'(f_rsp_rdata), 32'(r.data));
            end
        end
        if (m_irq_a === 1'b1) begin
            if (irq_a_q.size() == 0) unexpected("irq_a");
            else begin
                c = irq_a_q.pop_front();
                check("irq_a cycle", 32'(cyc), 32'(c));
            end
        end
        if (m_irq_b === 1'b1) unexpected("irq_b");
        if ((f_irq_a | f_irq_b) === 1'b1) unexpected("irq dut1");
        if (cyc >= 2) begin
            check("strobe overlap dut0", 32'(m_rdb | m_wrb), 32'd1);
            check("strobe overlap dut1", 32'(f_rdb | f_wrb), 32'd1);
        end
    end

    initial begin
        resetb = 1'b0; cmd_valid = 1'b0; f_cmd_valid = 1'b0;
        cmd_write = 1'b0; cmd_addr = 3'd0; cmd_wdata = 8'h00;
        data_in = 8'h00; intra_in = 1'b0; intrb_in = 1'b0;

        // Reset state, then ready once resetb is released.
        push_reset(0, 2, 1'b0);
        push_reset(1, 2, 1'b0);
        push_reset(0, 3, 1'b1);
        push_reset(1, 3, 1'b1);
        goto(3); resetb = 1'b1;

        // Write 0x80 to address 3.
        push_txn(0, 5, 1'b1, 3'd3, 8'h80, 8'h00, 2, 4, 2, 0);
        goto(5); cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 3'd3; cmd_wdata = 8'h80;
        goto(6); cmd_valid = 1'b0;

        // Read address 0 returning 0x5A.
        push_txn(0, 16, 1'b0, 3'd0, 8'h00, 8'h5A, 2, 4, 2, 0);
        goto(16); cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 3'd0; cmd_wdata = 8'h00;
        data_in = 8'h5A;
        goto(17); cmd_valid = 1'b0;

        // Back-to-back write then read with cmd_valid held high.
        push_txn(0, 27, 1'b1, 3'd5, 8'h3C, 8'h00, 2, 4, 2, 0);
        push_txn(0, 36, 1'b0, 3'd6, 8'h00, 8'hC3, 2, 4, 2, 0);
        goto(27); cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 3'd5; cmd_wdata = 8'h3C;
        goto(28); cmd_write = 1'b0; cmd_addr = 3'd6; cmd_wdata = 8'h00; data_in = 8'hC3;
        goto(37); cmd_valid = 1'b0;

        // Read aborted by reset during its second strobe cycle.
        push_txn(0, 50, 1'b0, 3'd2, 8'h00, 8'h77, 2, 4, 2, 54);
        for (int n = 55; n <= 57; n++) push_reset(0, n, 1'b1);
        goto(50); cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 3'd2; data_in = 8'h77;
        goto(51); cmd_valid = 1'b0;
        goto(54); resetb = 1'b0;
        goto(55); resetb = 1'b1;

        // INTRA held high: one pulse three cycles after the rise.
        irq_a_q.push_back(63);
        goto(60); intra_in = 1'b1;
        goto(80); intra_in = 1'b0;

        // Minimum timing instance: strobe k+2, response k+3, ready k+4.
        push_txn(1, 85, 1'b0, 3'd1, 8'h00, 8'h99, 1, 1, 1, 0);
        goto(85); f_cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 3'd1; data_in = 8'h99;
        goto(86); f_cmd_valid = 1'b0;

        goto(100);
        foreach (snap_q[i]) unexpected($sformatf("trace dut%0d cyc%0d never observed", snap_q[i].dut, snap_q[i].cyc));
        foreach (rsp_q0[i]) unexpected($sformatf("missing rsp dut0 cyc%0d", rsp_q0[i].cyc));
        foreach (rsp_q1[i]) unexpected($sformatf("missing rsp dut1 cyc%0d", rsp_q1[i].cyc));
        foreach (irq_a_q[i]) unexpected($sformatf("missing irq_a cyc%0d", irq_a_q[i]));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
